// File: rtl/csr_wr_unit_pkg.sv
// csr_wr_unit_pkg: CSR addresses, op codes, FSM states
// and the address decoder shared by the CSR write unit.
package csr_wr_unit_pkg;

  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    SEL_NONE    = 3'd0,
    SEL_SCRATCH = 3'd1,
    SEL_EPC     = 3'd2,
    SEL_CAUSE   = 3'd3,
    SEL_TVEC    = 3'd4,
    SEL_RET_LO  = 3'd5,
    SEL_RET_HI  = 3'd6
  } csr_sel_t;

  // Map a CSR address onto the register it selects.
  function automatic csr_sel_t csr_decode(
    input logic [11:0] adr
  );
    csr_sel_t sel;
    sel = SEL_NONE;
    case (adr)
      CSR_MSCRATCH:  sel = SEL_SCRATCH;
      CSR_MEPC:      sel = SEL_EPC;
      CSR_MCAUSE:    sel = SEL_CAUSE;
      CSR_MTVEC:     sel = SEL_TVEC;
      CSR_MINSTRET:  sel = SEL_RET_LO;
      CSR_MINSTRETH: sel = SEL_RET_HI;
      default:       sel = SEL_NONE;
    endcase
    return sel;
  endfunction

  // funct3 x00 is not a CSR op.
  function automatic logic op_valid(
    input logic [2:0] f3
  );
    return f3[1:0] != 2'b00;
  endfunction

  // Read-only space belongs to the counter CSR file.
  function automatic logic ro_space(
    input logic [11:0] adr
  );
    return adr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/csr_wr_unit_rmw_alu.sv
// csr_wr_unit_rmw_alu: source select and RW/RS/RC merge
// plus the write-enable rule for one CSR instruction.
module csr_wr_unit_rmw_alu
  import csr_wr_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1_val,
  input  logic [4:0]      i_rs1_idx,
  input  logic [XLEN-1:0] i_old,
  output logic [XLEN-1:0] o_new,
  output logic            o_we
);

  logic [XLEN-1:0] w_src;
  logic            w_has_src;

  assign w_src = i_funct3[2] ? XLEN'(i_rs1_idx)
                             : i_rs1_val;

  // rs1 index (or uimm) of zero means "read only" for set/clear.
  assign w_has_src = i_rs1_idx != 5'd0;

  // Merge old value with the source per op.
  always_comb begin
    o_new = i_old;
    o_we  = 1'b0;
    unique case (1'b1)
      i_funct3[1:0] == OP_RW: begin
        o_new = w_src;
        o_we  = 1'b1;
      end
      i_funct3[1:0] == OP_RS: begin
        o_new = i_old | w_src;
        o_we  = w_has_src;
      end
      i_funct3[1:0] == OP_RC: begin
        o_new = i_old & ~w_src;
        o_we  = w_has_src;
      end
      default: begin
        o_new = i_old;
        o_we  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/csr_wr_unit.sv
// csr_wr_unit: read-modify-write unit for writable machine CSRs.
// Define CSR_WR_TRAP_EN to add the trap_valid/trap_pc/trap_cause port.
module csr_wr_unit
  import csr_wr_unit_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [11:0]     req_adr,
  input  logic [XLEN-1:0] req_rs1_val,
  input  logic [4:0]      req_rs1_idx,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_illegal,
  input  logic            instr_retire,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o
`ifdef CSR_WR_TRAP_EN
  ,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_cause
`endif
);

  localparam logic [XLEN-1:0] MEPC_MASK  = ~(XLEN'(3));
  localparam logic [XLEN-1:0] MTVEC_MASK = ~(XLEN'(2));
  localparam logic [2*XLEN-1:0] RET_ONE  = (2*XLEN)'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_funct3;
  logic [11:0]       r_adr;
  logic [XLEN-1:0]   r_rs1_val;
  logic [4:0]        r_rs1_idx;
  logic [XLEN-1:0]   r_old;
  logic              r_ill;

  logic [XLEN-1:0]   r_mscratch;
  logic [XLEN-1:0]   r_mepc;
  logic [XLEN-1:0]   r_mcause;
  logic [XLEN-1:0]   r_mtvec;
  logic [2*XLEN-1:0] r_minstret;

  csr_sel_t          w_sel;
  logic [XLEN-1:0]   w_rd_val;
  logic              w_ill;
  logic [XLEN-1:0]   w_new;
  logic              w_alu_we;
  logic              w_accept;
  logic              w_commit;
  logic              w_trap;
  logic              w_abort;
  logic [XLEN-1:0]   w_trap_pc;
  logic [XLEN-1:0]   w_trap_cause;

`ifdef CSR_WR_TRAP_EN
  assign w_trap       = trap_valid;
  assign w_trap_pc    = trap_pc & MEPC_MASK;
  assign w_trap_cause = trap_cause;
`else
  assign w_trap       = 1'b0;
  assign w_trap_pc    = '0;
  assign w_trap_cause = '0;
`endif

  assign w_accept = req_valid && req_ready;
  assign w_abort  = w_trap && (r_state != ST_IDLE);
  assign w_sel    = csr_decode(r_adr);

  assign w_ill = !op_valid(r_funct3)
              || (w_sel == SEL_NONE)
              || ro_space(r_adr);

  // Current value of the addressed CSR.
  always_comb begin
    w_rd_val = '0;
    case (w_sel)
      SEL_SCRATCH: w_rd_val = r_mscratch;
      SEL_EPC:     w_rd_val = r_mepc;
      SEL_CAUSE:   w_rd_val = r_mcause;
      SEL_TVEC:    w_rd_val = r_mtvec;
      SEL_RET_LO:  w_rd_val = r_minstret[XLEN-1:0];
      SEL_RET_HI:  w_rd_val = r_minstret[2*XLEN-1:XLEN];
      default:     w_rd_val = '0;
    endcase
  end

  csr_wr_unit_rmw_alu #(
    .XLEN (XLEN)
  ) u_alu (
    .i_funct3  (r_funct3),
    .i_rs1_val (r_rs1_val),
    .i_rs1_idx (r_rs1_idx),
    .i_old     (r_old),
    .o_new     (w_new),
    .o_we      (w_alu_we)
  );

  assign w_commit = (r_state == ST_WRITE)
                 && !r_ill && w_alu_we && !w_trap;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; a trap pulls an in-flight request back to idle.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (req_valid) w_state_nxt = ST_READ;
      ST_READ:  w_state_nxt = ST_WRITE;
      ST_WRITE: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (w_abort) w_state_nxt = ST_IDLE;
  end

  // Capture the request, then the old value and legality.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_funct3  <= '0;
      r_adr     <= '0;
      r_rs1_val <= '0;
      r_rs1_idx <= '0;
      r_old     <= '0;
      r_ill     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_funct3  <= req_funct3;
        r_adr     <= req_adr;
        r_rs1_val <= req_rs1_val;
        r_rs1_idx <= req_rs1_idx;
      end
      if (r_state == ST_READ) begin
        r_old <= w_ill ? '0 : w_rd_val;
        r_ill <= w_ill;
      end
    end
  end

  // Writable CSRs; a trap owns mepc/mcause that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtvec    <= MTVEC_RESET & MTVEC_MASK;
    end else if (w_trap) begin
      r_mepc   <= w_trap_pc;
      r_mcause <= w_trap_cause;
    end else if (w_commit) begin
      case (w_sel)
        SEL_SCRATCH: r_mscratch <= w_new;
        SEL_EPC:     r_mepc     <= w_new & MEPC_MASK;
        SEL_CAUSE:   r_mcause   <= w_new;
        SEL_TVEC:    r_mtvec    <= w_new & MTVEC_MASK;
        default:     ;
      endcase
    end
  end

  // Retired-instruction counter; an explicit write wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_minstret <= '0;
    end else if (w_commit && w_sel == SEL_RET_LO) begin
      r_minstret[XLEN-1:0] <= w_new;
    end else if (w_commit && w_sel == SEL_RET_HI) begin
      r_minstret[2*XLEN-1:XLEN] <= w_new;
    end else if (instr_retire) begin
      r_minstret <= r_minstret + RET_ONE;
    end
  end

  assign req_ready    = r_state == ST_IDLE;
  assign resp_valid   = (r_state == ST_WRITE) || w_abort;
  assign resp_illegal = resp_valid && (r_ill || w_abort);
  assign resp_rdata   = (r_state == ST_WRITE && !w_abort)
                      ? r_old : '0;
  assign mtvec_o      = r_mtvec;
  assign mepc_o       = r_mepc;

endmodule

// File: tb/tb_csr_wr_unit.sv
// tb_csr_wr_unit: random and directed CSR instructions
// checked every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_csr_wr_unit;

  localparam logic [31:0] MTVEC_RST = 32'h0000_1100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = '0;
  logic [11:0] req_adr = '0;
  logic [31:0] req_rs1_val = '0;
  logic [4:0]  req_rs1_idx = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_illegal;
  logic        instr_retire = 1'b0;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
`ifdef CSR_WR_TRAP_EN
  logic        trap_valid = 1'b0;
  logic [31:0] trap_pc = '0;
  logic [31:0] trap_cause = '0;
`endif

  csr_wr_unit #(
    .XLEN        (32),
    .MTVEC_RESET (MTVEC_RST)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct3   (req_funct3),
    .req_adr      (req_adr),
    .req_rs1_val  (req_rs1_val),
    .req_rs1_idx  (req_rs1_idx),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_illegal (resp_illegal),
    .instr_retire (instr_retire),
    .mtvec_o      (mtvec_o),
    .mepc_o       (mepc_o)
`ifdef CSR_WR_TRAP_EN
    ,
    .trap_valid   (trap_valid),
    .trap_pc      (trap_pc),
    .trap_cause   (trap_cause)
`endif
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Architectural model state.
  logic [31:0] m_scr, m_epc, m_cause, m_tvec;
  logic [63:0] m_ret;

  // Expected outputs for the current cycle.
  logic        chk_on = 1'b0;
  logic        exp_ready, exp_rv, exp_ill;
  logic [31:0] exp_rdata;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("req_ready", req_ready, exp_ready);
      check("resp_valid", resp_valid, exp_rv);
      if (exp_rv) begin
        check("resp_rdata", resp_rdata, exp_rdata);
        check("resp_illegal", resp_illegal, exp_ill);
      end
      check("mtvec_o", mtvec_o, m_tvec);
      check("mepc_o", mepc_o, m_epc);
    end
  end

  task automatic m_reset();
    m_scr = 0; m_epc = 0; m_cause = 0;
    m_tvec = MTVEC_RST & ~32'h2;
    m_ret = 0;
  endtask

  function automatic logic m_mapped(input logic [11:0] a);
    return a == 12'h340 || a == 12'h341 || a == 12'h342
        || a == 12'h305 || a == 12'hB02 || a == 12'hB82;
  endfunction

  function automatic logic m_illegal(input logic [2:0] f3,
                                     input logic [11:0] a);
    return f3[1:0] == 2'b00 || !m_mapped(a) || a[11:10] == 2'b11;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h340: return m_scr;
      12'h341: return m_epc;
      12'h342: return m_cause;
      12'h305: return m_tvec;
      12'hB02: return m_ret[31:0];
      12'hB82: return m_ret[63:32];
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_write(input logic [11:0] a,
                         input logic [31:0] v,
                         input logic r);
    case (a)
      12'h340: m_scr = v;
      12'h341: m_epc = v & ~32'h3;
      12'h342: m_cause = v;
      12'h305: m_tvec = v & ~32'h2;
      12'hB02: m_ret[31:0] = v;
      12'hB82: m_ret[63:32] = v;
      default: ;
    endcase
    if (r && a != 12'hB02 && a != 12'hB82) m_ret = m_ret + 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pick(input bit rnd, input logic b);
    return rnd ? logic'($urandom_range(0, 1)) : b;
  endfunction

  // One full CSR instruction; rp gives retire per cycle
  // (accept, read, write) unless rnd is set.
  task automatic do_req(input logic [2:0] f3,
                        input logic [11:0] a,
                        input logic [31:0] v,
                        input logic [4:0] idx,
                        input bit rnd,
                        input logic [2:0] rp,
                        output logic [31:0] grd,
                        output logic gill);
    logic [31:0] old, src, nv;
    logic ill, we, r;
    r = pick(rnd, rp[0]);
    req_valid = 1'b1; req_funct3 = f3; req_adr = a;
    req_rs1_val = v; req_rs1_idx = idx; instr_retire = r;
    exp_ready = 1'b1; exp_rv = 1'b0;
    tick();
    if (r) m_ret = m_ret + 1;
    req_valid = 1'b0;
    req_funct3 = 3'($urandom); req_adr = 12'($urandom);
    req_rs1_val = $urandom; req_rs1_idx = 5'($urandom);
    r = pick(rnd, rp[1]); instr_retire = r;
    exp_ready = 1'b0; exp_rv = 1'b0;
    ill = m_illegal(f3, a);
    old = ill ? 32'h0 : m_read(a);
    tick();
    if (r) m_ret = m_ret + 1;
    r = pick(rnd, rp[2]); instr_retire = r;
    exp_rv = 1'b1; exp_rdata = old; exp_ill = ill;
    src = f3[2] ? {27'b0, idx} : v;
    case (f3[1:0])
      2'b01:   nv = src;
      2'b10:   nv = old | src;
      2'b11:   nv = old & ~src;
      default: nv = old;
    endcase
    we = !ill && (f3[1:0] == 2'b01 || idx != 5'd0);
    @(negedge clk);
    grd = resp_rdata; gill = resp_illegal;
    tick();
    if (we) m_write(a, nv, r);
    else if (r) m_ret = m_ret + 1;
    instr_retire = 1'b0;
    exp_ready = 1'b1; exp_rv = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] v);
    logic gi;
    do_req(3'b010, a, 32'h0, 5'd0, 1'b0, 3'b000, v, gi);
  endtask

  task automatic idle(input int n, input bit rnd);
    logic r;
    for (int i = 0; i < n; i++) begin
      r = pick(rnd, 1'b0); instr_retire = r;
      exp_ready = 1'b1; exp_rv = 1'b0;
      tick();
      if (r) m_ret = m_ret + 1;
    end
    instr_retire = 1'b0;
  endtask

  logic [31:0] g;
  logic        gi;
  logic [11:0] adrs [10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    n_miss++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    adrs = '{12'h340, 12'h341, 12'h342, 12'h305, 12'hB02,
             12'hB82, 12'hC00, 12'h7FF, 12'hB00, 12'h000};
    m_reset();
    exp_ready = 1'b1; exp_rv = 1'b0; exp_ill = 1'b0; exp_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_on = 1'b1;
    @(negedge clk);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_illegal", resp_illegal, 1'b0);
    tick();
    rst_n = 1'b1;
    idle(1, 1'b0);

    // Write/read-back of mscratch.
    do_req(3'b001, 12'h340, 32'hDEADBEEF, 5'd5, 0, 3'b000, g, gi);
    check("t1_rdata0", g, 32'h0);
    check("t1_ill0", gi, 1'b0);
    do_req(3'b001, 12'h340, 32'h0, 5'd5, 0, 3'b000, g, gi);
    check("t1_rdata1", g, 32'hDEADBEEF);

    // Set/clear forms.
    do_req(3'b001, 12'h340, 32'hF0F0, 5'd1, 0, 3'b000, g, gi);
    do_req(3'b010, 12'h340, 32'h000F, 5'd3, 0, 3'b000, g, gi);
    check("t2_rs_old", g, 32'hF0F0);
    rd(12'h340, g);
    check("t2_rs_new", g, 32'hF0FF);
    do_req(3'b111, 12'h340, 32'hFFFF_FFFF, 5'h0F, 0, 3'b000, g, gi);
    check("t2_rci_old", g, 32'hF0FF);
    do_req(3'b010, 12'h340, 32'hFFFF, 5'd0, 0, 3'b000, g, gi);
    check("t2_rci_new", g, 32'hF0F0);
    rd(12'h340, g);
    check("t2_rs_x0", g, 32'hF0F0);

    // mepc alignment and illegal accesses.
    do_req(3'b001, 12'h341, 32'h1003, 5'd2, 0, 3'b000, g, gi);
    @(negedge clk);
    check("t3_mepc", mepc_o, 32'h1000);
    tick();
    do_req(3'b001, 12'hC00, 32'h1234, 5'd2, 0, 3'b000, g, gi);
    check("t3_c00_ill", gi, 1'b1);
    check("t3_c00_rd", g, 32'h0);
    do_req(3'b100, 12'h340, 32'h1, 5'd2, 0, 3'b000, g, gi);
    check("t3_f100_ill", gi, 1'b1);
    do_req(3'b001, 12'h7FF, 32'h1, 5'd2, 0, 3'b000, g, gi);
    check("t3_7ff_ill", gi, 1'b1);
    do_req(3'b101, 12'h305, 32'h0, 5'h1F, 0, 3'b000, g, gi);
    check("t3_mtvec_old", g, MTVEC_RST);
    check("t3_mtvec_b1", mtvec_o, 32'h1D);

    // minstret counting and write-wins.
    idle(5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      instr_retire = 1'b1; exp_ready = 1'b1; exp_rv = 1'b0;
      tick();
      m_ret = m_ret + 1;
    end
    instr_retire = 1'b0;
    rd(12'hB02, g);
    check("t4_ret5", g, 32'd5);
    do_req(3'b001, 12'hB02, 32'd100, 5'd1, 0, 3'b100, g, gi);
    rd(12'hB02, g);
    check("t4_ret100", g, 32'd100);
    do_req(3'b001, 12'hB02, 32'hFFFF_FFFF, 5'd1, 0, 3'b100, g, gi);
    rd(12'hB02, g);
    check("t4_lo_ff", g, 32'hFFFF_FFFF);
    rd(12'hB82, g);
    check("t4_hi", g, 32'h0);

    // Reset during READ.
    do_req(3'b001, 12'h340, 32'h1234, 5'd1, 0, 3'b000, g, gi);
    req_valid = 1'b1; req_funct3 = 3'b001; req_adr = 12'h340;
    req_rs1_val = 32'h9999; req_rs1_idx = 5'd1;
    exp_ready = 1'b1; exp_rv = 1'b0;
    tick();
    req_valid = 1'b0;
    rst_n = 1'b0;
    m_reset();
    exp_ready = 1'b1; exp_rv = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    idle(3, 1'b0);
    rd(12'h340, g);
    check("t5_scr", g, 32'h0);

`ifdef CSR_WR_TRAP_EN
    // Trap while a request sits in READ.
    do_req(3'b001, 12'h340, 32'h77, 5'd1, 0, 3'b000, g, gi);
    req_valid = 1'b1; req_funct3 = 3'b001; req_adr = 12'h340;
    req_rs1_val = 32'h5; req_rs1_idx = 5'd1;
    exp_ready = 1'b1; exp_rv = 1'b0;
    tick();
    req_valid = 1'b0;
    trap_valid = 1'b1; trap_pc = 32'h207; trap_cause = 32'd11;
    exp_ready = 1'b0; exp_rv = 1'b1; exp_rdata = 0; exp_ill = 1'b1;
    tick();
    trap_valid = 1'b0;
    m_epc = 32'h204; m_cause = 32'd11;
    exp_ready = 1'b1; exp_rv = 1'b0;
    check("t6_mepc", mepc_o, 32'h204);
    rd(12'h342, g);
    check("t6_mcause", g, 32'd11);
    rd(12'h340, g);
    check("t6_scr", g, 32'h77);
`endif

    // Randomized instruction stream.
    for (int n = 0; n < 300; n++) begin
      logic [2:0]  f3;
      logic [11:0] a;
      logic [4:0]  idx;
      int k;
      f3 = 3'($urandom);
      k = $urandom_range(0, 10);
      a = (k == 10) ? 12'($urandom) : adrs[k];
      idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      do_req(f3, a, $urandom, idx, 1'b1, 3'b000, g, gi);
      idle($urandom_range(0, 2), 1'b1);
    end
    for (int k = 0; k < 6; k++) rd(adrs[k], g);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
